uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001 SHALL have parameter DBIT, default 8: data bits per frame, legal range 5..8.
- REQ-002 SHALL have parameter SB_TICK, default 16: stop-bit length in baud ticks; 16, 24 and 32 give 1, 1.5 and 2 stop bits.
- REQ-003 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
- REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
- REQ-005 SHALL have port s_tick, input, 1 bit: one-clk baud tick pulse at 16x the bit rate.
- REQ-006 SHALL have port fifo_empty, input, 1 bit: empty flag of the transmit FIFO read side.
- REQ-007 SHALL have port fifo_data, input, DBIT bits: FIFO head word; fall-through, valid whenever fifo_empty=0.
- REQ-008 SHALL have port fifo_rd, output, 1 bit: FIFO pop strobe; the head word is consumed on the edge where it is high.
- REQ-009 SHALL have port tx, output, 1 bit: serial line, idle high.
- REQ-010 SHALL have port tx_busy, output, 1 bit: high whenever the FSM is not in IDLE.
- REQ-011 SHALL have port tx_done, output, 1 bit: one-clk pulse when a frame's stop bit completes.

Function
- REQ-012 SHALL implement the FSM states IDLE, START, DATA and STOP, with tick counter s (5 bits), bit counter n (3 bits) and shift register b (DBIT bits).
- REQ-013 In IDLE with fifo_empty=0, the block SHALL assert fifo_rd combinationally for exactly that cycle.
- REQ-014 On the same edge as REQ-013, the block SHALL load b from fifo_data, clear s and enter START.
- REQ-015 The block SHALL never assert fifo_rd outside IDLE or while fifo_empty=1.
- REQ-016 In START, tx SHALL be 0; on each s_tick, s SHALL increment; on the s_tick where s=15, s SHALL clear, n SHALL clear and the FSM SHALL enter DATA.
- REQ-017 In DATA, tx SHALL equal b[0] (LSB first); on the s_tick where s=15, s SHALL clear and b SHALL shift right by one.
- REQ-018 On that same s_tick, the FSM SHALL enter STOP if n=DBIT-1; otherwise n SHALL increment.
- REQ-019 In STOP, tx SHALL be 1; on the s_tick where s=SB_TICK-1, the FSM SHALL enter IDLE and tx_done SHALL pulse for one clk.
- REQ-020 tx SHALL be registered: tx_reg is loaded from its next value on the same edge as the state, so tx never glitches.
- REQ-021 Cycles without s_tick SHALL hold s, n, b and the state unchanged; s_tick SHALL be ignored in IDLE.
- REQ-022 Frame length SHALL be exactly 16*(1+DBIT)+SB_TICK ticks from entry to START until the return to IDLE.
- REQ-023 Back-to-back frames SHALL spend exactly one clk in IDLE (the pop cycle) between frames, with no extra idle bit time.
- REQ-024 A word whose fifo_empty falls mid-frame SHALL NOT be popped until the FSM returns to IDLE.

Reset
- REQ-025 While reset is high, the block SHALL set the state to IDLE, tx=1, fifo_rd=0, tx_busy=0, tx_done=0, and s=0, n=0, b=0.
- REQ-026 A reset mid-frame SHALL abort the frame: tx returns high immediately and asynchronously, the popped byte is lost, and there SHALL be no re-pop or partial stop bit.

Structure
- REQ-027 The shared package uart_pkg SHALL hold the state enumeration, the OVERSAMPLE=16 constant and the DBIT/SB_TICK defaults.
- REQ-028 The block SHALL be a single module with no sub-module; the baud tick generator and the FIFO are external.

Verification
- REQ-029 s_tick tied to 1, FIFO holds 0x55 -> one fifo_rd pulse; tx low for 16 clks, then 1,0,1,0,1,0,1,0 at 16 clks each, then high for 16 clks; tx_done at clk 160 after the pop.
- REQ-030 FIFO holds 0xA5 then 0x3C, s_tick every clk -> two pops 161 clks apart; second start bit begins 1 clk after the first tx_done; bits LSB-first 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- REQ-031 FIFO empty for 1000 clks with s_tick toggling -> fifo_rd, tx_busy and tx_done stay 0 and tx stays 1.
- REQ-032 s_tick every 4th clk, byte 0xFF -> each bit lasts exactly 64 clks; state holds between ticks.
- REQ-033 Reset asserted during DATA bit 3 of 0x0F -> tx=1 and tx_busy=0 immediately; after release, the next FIFO word is popped and sent cleanly.
- REQ-034 SB_TICK=32, DBIT=7, byte 0x41 -> 7 data bits then a stop bit of 32 ticks; frame length 160 ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding,
// oversampling ratio and the default frame parameters.
package uart_pkg;

  // Baud ticks per bit time (the tick runs at 16x the bit rate).
  localparam int OVERSAMPLE = 16;

  // Default frame shape: 8 data bits, one stop bit (16 ticks).
  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;

  // Transmitter FSM state enumeration.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: pops words from a fall-through FIFO and serialises them
// as start bit, DBIT data bits (LSB first) and a stop bit of SB_TICK ticks.
//
// FIFO handshake: the FIFO presents a valid head word whenever fifo_empty=0
// (valid = ~fifo_empty). fifo_rd acts as ready: it is high only in IDLE
// while fifo_empty=0, and the word is transferred on the rising clk edge
// where both are high. A word arriving mid-frame waits until IDLE.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,    // legal range 5..8
  parameter int SB_TICK = SB_TICK_DEFAULT  // 16, 24 or 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done
);

  // Terminal counts, sized to the counters they are compared against.
  localparam logic [4:0] S_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] SB_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST  = 3'(DBIT - 1);

  state_t          state_reg, state_next;
  logic [4:0]      s_reg, s_next;
  logic [2:0]      n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            tx_reg, tx_next;
  logic            done_reg, done_next;
  logic            fifo_pop;

  // Next-state logic for the FSM, tick/bit counters and shift register.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    fifo_pop   = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // s_tick is irrelevant here; a waiting word starts a frame at once.
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          b_next     = fifo_data;
          s_next     = 5'd0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            s_next     = 5'd0;
            n_next     = 3'd0;
            state_next = ST_DATA;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            s_next = 5'd0;
            b_next = b_reg >> 1;
            if (n_reg == N_LAST) begin
              state_next = ST_STOP;
            end else begin
              n_next = n_reg + 3'd1;
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_reg == SB_LAST) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Line level follows the state being entered so tx and state change on
  // the same edge; in DATA it shows the bit about to be shifted out.
  always_comb begin
    case (state_next)
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = b_next[0];
      default:  tx_next = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and drives the line idle high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      s_reg     <= 5'd0;
      n_reg     <= 3'd0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
      done_reg  <= done_next;
    end
  end

  // The pop strobe is masked during reset so a held reset never consumes
  // the FIFO head word.
  assign fifo_rd = fifo_pop & ~reset;
  assign tx      = tx_reg;
  assign tx_busy = (state_reg != ST_IDLE);
  assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a table of single frames at several tick
// rates, plus hand sequences for idle, back-to-back, reset abort and a
// 7-bit / 2-stop-bit instance.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd, tx, tx_busy, tx_done;

  logic       fifo2_empty;
  logic [6:0] fifo2_data;
  logic       fifo2_rd, tx2, tx2_busy, tx2_done;

  logic [7:0] q[$];
  int         tick_div;
  int         tick_cnt;
  int         n_checks;
  int         n_errors;

  logic tx_log   [1024];
  logic done_log [1024];
  logic busy_log [1024];
  logic rd_log   [1024];
  logic tx2_log  [1024];
  logic done2_log[1024];
  logic busy2_log[1024];
  logic rd2_log  [1024];

  typedef struct {
    logic [7:0] data;
    int         div;       // clocks per s_tick
    logic [9:0] exp_bits;  // bit i = expected line level in bit slot i
    int         len;       // clocks from pop edge to tx_done
  } vec_t;

  vec_t vecs[4];

  // Clock generation.
  always #5 clk = ~clk;

  uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_tick     (s_tick),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  uart_tx #(.DBIT(7), .SB_TICK(32)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .s_tick     (s_tick),
    .fifo_empty (fifo2_empty),
    .fifo_data  (fifo2_data),
    .fifo_rd    (fifo2_rd),
    .tx         (tx2),
    .tx_busy    (tx2_busy),
    .tx_done    (tx2_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // One clock: pop whatever the DUTs strobed, then set up the next s_tick.
  task automatic cycle();
    logic pend, pend2;
    #1;
    pend  = fifo_rd;
    pend2 = fifo2_rd;
    @(posedge clk);
    #1;
    if (pend && q.size() != 0) q.delete(0);
    if (pend2) fifo2_empty = 1'b1;
    refresh();
    @(negedge clk);
    tick_cnt = (tick_cnt + 1) % tick_div;
    s_tick   = (tick_cnt == 0);
  endtask

  // Next edge carries a tick, then one every d clocks.
  task automatic set_div(input int d);
    tick_div = d;
    tick_cnt = 0;
    s_tick   = 1'b1;
  endtask

  task automatic capture(input int n);
    #1;
    tx_log[0] = tx;   done_log[0] = tx_done;   busy_log[0] = tx_busy;   rd_log[0] = fifo_rd;
    tx2_log[0] = tx2; done2_log[0] = tx2_done; busy2_log[0] = tx2_busy; rd2_log[0] = fifo2_rd;
    for (int k = 1; k <= n; k++) begin
      cycle();
      #1;
      tx_log[k] = tx;   done_log[k] = tx_done;   busy_log[k] = tx_busy;   rd_log[k] = fifo_rd;
      tx2_log[k] = tx2; done2_log[k] = tx2_done; busy2_log[k] = tx2_busy; rd2_log[k] = fifo2_rd;
    end
  endtask

  // base = log index of the edge that enters START.
  task automatic check_frame(input int sel, input int base, input int div,
                             input logic [9:0] exp_bits, input int len, input string tag);
    int bt;
    int k;
    bt = 16 * div;
    check($sformatf("%s idle_before", tag), sel ? tx2_log[base-1] : tx_log[base-1], 1);
    check($sformatf("%s start_first", tag), sel ? tx2_log[base] : tx_log[base], 0);
    check($sformatf("%s start_last", tag), sel ? tx2_log[base+bt-1] : tx_log[base+bt-1], 0);
    check($sformatf("%s d0_first", tag), sel ? tx2_log[base+bt] : tx_log[base+bt], 32'(exp_bits[1]));
    for (int j = 0; j < 10; j++) begin
      k = base + bt * j + bt / 2;
      check($sformatf("%s slot%0d", tag, j), sel ? tx2_log[k] : tx_log[k], 32'(exp_bits[j]));
    end
    check($sformatf("%s done_early", tag), sel ? done2_log[base+len-1] : done_log[base+len-1], 0);
    check($sformatf("%s done", tag), sel ? done2_log[base+len] : done_log[base+len], 1);
    check($sformatf("%s busy_end", tag), sel ? busy2_log[base+len-1] : busy_log[base+len-1], 1);
    check($sformatf("%s idle_end", tag), sel ? busy2_log[base+len] : busy_log[base+len], 0);
  endtask

  function automatic int count_log(input int sel, input int n);
    int c;
    c = 0;
    for (int k = 0; k <= n; k++) begin
      case (sel)
        0: c += int'(rd_log[k]);
        1: c += int'(done_log[k]);
        2: c += int'(rd2_log[k]);
        default: c += int'(done2_log[k]);
      endcase
    end
    return c;
  endfunction

  initial begin
    int bad;
    int r2;
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    fifo2_empty = 1'b1;
    fifo2_data  = 7'h00;
    set_div(1);
    refresh();

    vecs[0] = '{8'h55, 1, 10'b1010101010, 160};
    vecs[1] = '{8'hFF, 4, 10'b1111111110, 640};
    vecs[2] = '{8'h00, 1, 10'b1000000000, 160};
    vecs[3] = '{8'h81, 2, 10'b1100000010, 320};

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst tx", tx, 1);
    check("rst busy", tx_busy, 0);
    check("rst done", tx_done, 0);
    check("rst rd", fifo_rd, 0);
    check("rst tx2", tx2, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) cycle();

    // Empty FIFO with a toggling tick: nothing may move.
    set_div(2);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      #1;
      if (fifo_rd || tx_busy || tx_done || !tx) bad++;
    end
    check("idle violations", bad, 0);

    // Table of single frames.
    foreach (vecs[i]) begin
      set_div(vecs[i].div);
      q.push_back(vecs[i].data);
      refresh();
      capture(vecs[i].len + 4);
      check_frame(0, 1, vecs[i].div, vecs[i].exp_bits, vecs[i].len,
                  $sformatf("vec%0d", i));
      check($sformatf("vec%0d pops", i), count_log(0, vecs[i].len + 4), 1);
      check($sformatf("vec%0d dones", i), count_log(1, vecs[i].len + 4), 1);
    end

    // Back-to-back frames 0xA5 then 0x3C.
    set_div(1);
    q.push_back(8'hA5);
    q.push_back(8'h3C);
    refresh();
    capture(330);
    r2 = -1;
    for (int k = 1; k <= 330; k++) if (rd_log[k] && r2 < 0) r2 = k;
    check("b2b pop spacing", r2, 161);
    check("b2b pops", count_log(0, 330), 2);
    check("b2b dones", count_log(1, 330), 2);
    check_frame(0, 1, 1, 10'b1101001010, 160, "b2b0");
    check_frame(0, 162, 1, 10'b1001111000, 160, "b2b1");

    // Reset during data bit 3 of 0x0F, with 0x96 queued behind it.
    set_div(1);
    q.push_back(8'h0F);
    q.push_back(8'h96);
    refresh();
    capture(73);
    check("abort busy_before", busy_log[73], 1);
    reset = 1'b1;
    #1;
    check("abort tx", tx, 1);
    check("abort busy", tx_busy, 0);
    check("abort done", tx_done, 0);
    check("abort rd", fifo_rd, 0);
    repeat (3) cycle();
    check("abort queue kept", q.size(), 1);
    reset = 1'b0;
    capture(170);
    check_frame(0, 1, 1, 10'b1100101100, 160, "after_abort");
    check("after_abort pops", count_log(0, 170), 1);
    check("after_abort queue", q.size(), 0);

    // 7 data bits, 2 stop bits: 0x41.
    set_div(1);
    fifo2_data  = 7'h41;
    fifo2_empty = 1'b0;
    capture(170);
    check_frame(1, 1, 1, 10'b1110000010, 160, "d7");
    check("d7 pops", count_log(2, 170), 1);
    check("d7 dones", count_log(3, 170), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
